// File: rtl/dcache_pkg.sv
// Shared constants, FSM state type and address field helpers for the data cache.
package dcache_pkg;
   localparam int ADDR_W      = 8;
   localparam int INDEX_BITS  = 3;
   localparam int OFFSET_BITS = 2;
   localparam int TAG_BITS    = ADDR_W - INDEX_BITS - OFFSET_BITS;
   localparam int NUM_BLOCKS  = 1 << INDEX_BITS;
   localparam int BLOCK_W     = 32;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      FETCH     = 2'd2
   } state_t;

   function automatic logic [TAG_BITS-1:0] addr_tag(input logic [ADDR_W-1:0] a);
      return a[ADDR_W-1 -: TAG_BITS];
   endfunction

   function automatic logic [INDEX_BITS-1:0] addr_index(input logic [ADDR_W-1:0] a);
      return a[OFFSET_BITS +: INDEX_BITS];
   endfunction

   function automatic logic [OFFSET_BITS-1:0] addr_offset(input logic [ADDR_W-1:0] a);
      return a[OFFSET_BITS-1:0];
   endfunction
endpackage

// File: rtl/dcache_controller_if.sv
// CPU-side byte port and memory-side block port of the data cache.
interface dcache_cpu_if;
   import dcache_pkg::*;
   logic              READ;
   logic              WRITE;
   logic [ADDR_W-1:0] ADDRESS;
   logic [7:0]        WRITEDATA;
   logic [7:0]        READDATA;
   logic              BUSYWAIT;

   modport master (output READ, WRITE, ADDRESS, WRITEDATA, input READDATA, BUSYWAIT);
   modport slave  (input READ, WRITE, ADDRESS, WRITEDATA, output READDATA, BUSYWAIT);
endinterface

interface dcache_mem_if;
   import dcache_pkg::*;
   logic                           MEM_READ;
   logic                           MEM_WRITE;
   logic [TAG_BITS+INDEX_BITS-1:0] MEM_ADDRESS;
   logic [BLOCK_W-1:0]             MEM_WRITEDATA;
   logic [BLOCK_W-1:0]             MEM_READDATA;
   logic                           MEM_BUSYWAIT;

   modport master (output MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
                   input MEM_READDATA, MEM_BUSYWAIT);
   modport slave  (input MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
                   output MEM_READDATA, MEM_BUSYWAIT);
endinterface

// File: rtl/dcache_block_array.sv
// Tag/valid/dirty/data storage for the direct-mapped cache; one indexed entry,
// read combinationally, written by a byte port or a whole-block fill.
module dcache_block_array
   import dcache_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [INDEX_BITS-1:0]  index,
   output logic                   valid,
   output logic                   dirty,
   output logic [TAG_BITS-1:0]    tag,
   output logic [BLOCK_W-1:0]     data,
   input  logic                   byte_we,
   input  logic [OFFSET_BITS-1:0] byte_offset,
   input  logic [7:0]             byte_data,
   input  logic                   fill_we,
   input  logic [TAG_BITS-1:0]    fill_tag,
   input  logic [BLOCK_W-1:0]     fill_data
);
   logic [NUM_BLOCKS-1:0] valid_q;
   logic [NUM_BLOCKS-1:0] dirty_q;
   logic [TAG_BITS-1:0]   tag_q  [NUM_BLOCKS];
   logic [BLOCK_W-1:0]    data_q [NUM_BLOCKS];

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (fill_we) begin
         valid_q[index] <= 1'b1;
         dirty_q[index] <= 1'b0;
      end else if (byte_we) begin
         dirty_q[index] <= 1'b1;
      end
   end

   // Tag and data carry no reset; valid alone qualifies them.
   always_ff @(posedge clk) begin
      if (fill_we) begin
         tag_q[index]  <= fill_tag;
         data_q[index] <= fill_data;
      end else if (byte_we) begin
         data_q[index][{byte_offset, 3'b000} +: 8] <= byte_data;
      end
   end

   assign valid = valid_q[index];
   assign dirty = dirty_q[index];
   assign tag   = tag_q[index];
   assign data  = data_q[index];
endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate data cache controller.
// Optional DCACHE_STATS_EN adds saturating HIT_COUNT/MISS_COUNT outputs.
//  state     | meaning
//  IDLE      | serve hits with zero stall; a miss picks WRITEBACK or FETCH
//  WRITEBACK | write the dirty victim block to memory
//  FETCH     | read the requested block from memory and fill the entry
module dcache_controller
   import dcache_pkg::*;
(
   input  logic          CLK,
   input  logic          RESET,
   dcache_cpu_if.slave   cpu,
   dcache_mem_if.master  mem
`ifdef DCACHE_STATS_EN
   ,
   output logic [15:0]   HIT_COUNT,
   output logic [15:0]   MISS_COUNT
`endif
);
   state_t                state;
   logic [TAG_BITS-1:0]   req_tag;
   logic [INDEX_BITS-1:0] req_index;
   logic [INDEX_BITS-1:0] index;
   logic                  blk_valid;
   logic                  blk_dirty;
   logic [TAG_BITS-1:0]   blk_tag;
   logic [BLOCK_W-1:0]    blk_data;
   logic                  req;
   logic                  hit;
   logic                  miss;
   logic                  byte_we;
   logic                  fill_we;

   // A request seen while RESET is high is ignored so outputs read as idle.
   assign req     = (cpu.READ | cpu.WRITE) & ~RESET;
   assign index   = (state == IDLE) ? addr_index(cpu.ADDRESS) : req_index;
   assign hit     = blk_valid & (blk_tag == addr_tag(cpu.ADDRESS));
   assign miss    = (state == IDLE) & req & ~hit;
   assign byte_we = (state == IDLE) & req & cpu.WRITE & hit;
   assign fill_we = (state == FETCH) & ~mem.MEM_BUSYWAIT & ~RESET;

   dcache_block_array u_array (
      .clk         (CLK),
      .rst         (RESET),
      .index       (index),
      .valid       (blk_valid),
      .dirty       (blk_dirty),
      .tag         (blk_tag),
      .data        (blk_data),
      .byte_we     (byte_we),
      .byte_offset (addr_offset(cpu.ADDRESS)),
      .byte_data   (cpu.WRITEDATA),
      .fill_we     (fill_we),
      .fill_tag    (req_tag),
      .fill_data   (mem.MEM_READDATA)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= IDLE;
         req_tag   <= '0;
         req_index <= '0;
      end else begin
         case (state)
            IDLE: if (miss) begin
               req_tag   <= addr_tag(cpu.ADDRESS);
               req_index <= addr_index(cpu.ADDRESS);
               state     <= (blk_valid & blk_dirty) ? WRITEBACK : FETCH;
            end
            WRITEBACK: if (!mem.MEM_BUSYWAIT) state <= FETCH;
            FETCH:     if (!mem.MEM_BUSYWAIT) state <= IDLE;
            default:   state <= IDLE;
         endcase
      end
   end

   assign cpu.BUSYWAIT = (state != IDLE) | miss;
   assign cpu.READDATA = ((state == IDLE) & req & ~cpu.WRITE & hit)
                         ? blk_data[{addr_offset(cpu.ADDRESS), 3'b000} +: 8] : 8'h00;

   // The victim tag stays in the array until the fill, so it is stable here.
   assign mem.MEM_READ      = (state == FETCH);
   assign mem.MEM_WRITE     = (state == WRITEBACK);
   assign mem.MEM_ADDRESS   = (state == WRITEBACK) ? {blk_tag, req_index} :
                              (state == FETCH)     ? {req_tag, req_index} : '0;
   assign mem.MEM_WRITEDATA = (state == WRITEBACK) ? blk_data : '0;

`ifdef DCACHE_STATS_EN
   logic just_filled;

   // The IDLE cycle right after a fill belongs to the request that missed.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         HIT_COUNT   <= '0;
         MISS_COUNT  <= '0;
         just_filled <= 1'b0;
      end else begin
         just_filled <= fill_we;
         if ((state == IDLE) && req && !just_filled) begin
            if (hit && (HIT_COUNT != 16'hFFFF))
               HIT_COUNT <= HIT_COUNT + 16'd1;
            else if (!hit && (MISS_COUNT != 16'hFFFF))
               MISS_COUNT <= MISS_COUNT + 16'd1;
         end
      end
   end
`endif
endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: behavioural cache/memory model, latency-programmable
// memory responder, directed scenarios and a randomized access stream.
module tb_dcache_controller;
   typedef struct packed {
      logic        wr;
      logic [5:0]  addr;
      logic [31:0] data;
   } xfer_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dcache_cpu_if cpu ();
   dcache_mem_if mem ();
`ifdef DCACHE_STATS_EN
   logic [15:0] hit_count, miss_count;
`endif

   dcache_controller dut (
      .CLK   (clk),
      .RESET (rst),
      .cpu   (cpu),
      .mem   (mem)
`ifdef DCACHE_STATS_EN
      ,
      .HIT_COUNT  (hit_count),
      .MISS_COUNT (miss_count)
`endif
   );

   int checks = 0;
   int errors = 0;

   logic [31:0] phys_mem [64];
   logic [31:0] ref_mem  [64];
   logic [31:0] m_data   [8];
   logic [2:0]  m_tag    [8];
   bit          m_valid  [8];
   bit          m_dirty  [8];
   int          m_hits   = 0;
   int          m_misses = 0;
   xfer_t       exp_q[$];
   xfer_t       got_q[$];

   int          mem_lat = 0;
   bit          in_xfer = 0;
   int          left = 0;
   logic [5:0]  x_addr;
   logic        x_wr;

   // Memory responder: holds MEM_BUSYWAIT high mem_lat cycles per transfer.
   always @(negedge clk) begin
      if (mem.MEM_READ === 1'b1 && mem.MEM_WRITE === 1'b1) begin
         checks++; errors++;
         $display("FAIL mem_exclusive: MEM_READ and MEM_WRITE both high at %0t", $time);
      end
      if ((mem.MEM_READ === 1'b1 || mem.MEM_WRITE === 1'b1) && !rst) begin
         if (!in_xfer) begin
            in_xfer = 1; left = mem_lat; x_addr = mem.MEM_ADDRESS; x_wr = mem.MEM_WRITE;
         end else begin
            checks++;
            if (mem.MEM_ADDRESS !== x_addr || mem.MEM_WRITE !== x_wr) begin
               errors++;
               $display("FAIL xfer_stable: addr %h wr %b, required addr %h wr %b",
                        mem.MEM_ADDRESS, mem.MEM_WRITE, x_addr, x_wr);
            end
         end
         if (left > 0) begin
            mem.MEM_BUSYWAIT = 1'b1;
            left--;
         end else begin
            mem.MEM_BUSYWAIT = 1'b0;
            if (x_wr) begin
               phys_mem[x_addr] = mem.MEM_WRITEDATA;
               got_q.push_back('{wr: 1'b1, addr: x_addr, data: mem.MEM_WRITEDATA});
            end else begin
               mem.MEM_READDATA = phys_mem[x_addr];
               got_q.push_back('{wr: 1'b0, addr: x_addr, data: phys_mem[x_addr]});
            end
            in_xfer = 0;
         end
      end else begin
         mem.MEM_BUSYWAIT = 1'b0;
         in_xfer = 0;
      end
   end

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin m_valid[i] = 0; m_dirty[i] = 0; end
      m_hits = 0; m_misses = 0;
   endtask

   // Cache reference model: predicts hit, load byte and the memory transfers.
   task automatic model_access(input bit wr, input logic [7:0] a, input logic [7:0] d,
                               output bit h, output logic [7:0] rb);
      int tg, ix, of, blk;
      tg = int'(a) / 32; ix = (int'(a) / 4) % 8; of = int'(a) % 4;
      h = m_valid[ix] && (int'(m_tag[ix]) == tg);
      if (!h) begin
         if (m_valid[ix] && m_dirty[ix]) begin
            blk = int'(m_tag[ix]) * 8 + ix;
            ref_mem[blk] = m_data[ix];
            exp_q.push_back('{wr: 1'b1, addr: 6'(blk), data: m_data[ix]});
         end
         blk = tg * 8 + ix;
         exp_q.push_back('{wr: 1'b0, addr: 6'(blk), data: ref_mem[blk]});
         m_data[ix] = ref_mem[blk]; m_tag[ix] = 3'(tg); m_valid[ix] = 1; m_dirty[ix] = 0;
      end
      rb = 8'((m_data[ix] >> (8 * of)) & 32'hFF);
      if (wr) begin
         m_data[ix] = (m_data[ix] & ~(32'hFF << (8 * of))) | (32'(d) << (8 * of));
         m_dirty[ix] = 1;
      end
   endtask

   task automatic compare_traffic(input string name);
      checks++;
      if (got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL %s traffic_count: got %0d transfers, required %0d", name, got_q.size(), exp_q.size());
      end else begin
         foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL %s traffic[%0d]: got wr=%b addr=%h data=%h, required wr=%b addr=%h data=%h",
                     name, i, got_q[i].wr, got_q[i].addr, got_q[i].data,
                     exp_q[i].wr, exp_q[i].addr, exp_q[i].data);
         end
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic do_op(input string name, input bit rd, input bit wr,
                        input logic [7:0] a, input logic [7:0] d);
      bit exp_hit; logic [7:0] exp_byte; int stall, n_xfer, exp_stall;
      model_access(wr, a, d, exp_hit, exp_byte);
      n_xfer = exp_q.size();
      exp_stall = exp_hit ? 0 : 1 + n_xfer * (1 + mem_lat);
      if (exp_hit) m_hits++; else m_misses++;
      @(posedge clk); #1;
      cpu.READ = rd; cpu.WRITE = wr; cpu.ADDRESS = a; cpu.WRITEDATA = d;
      @(negedge clk);
      checks++;
      if (cpu.BUSYWAIT !== (exp_hit ? 1'b0 : 1'b1)) begin
         errors++;
         $display("FAIL %s busy_first: BUSYWAIT=%b, required %b", name, cpu.BUSYWAIT, !exp_hit);
      end
      stall = 0;
      while (cpu.BUSYWAIT === 1'b1 && stall < 300) begin stall++; @(negedge clk); end
      checks++;
      if (stall != exp_stall) begin
         errors++;
         $display("FAIL %s stall_cycles: got %0d, required %0d", name, stall, exp_stall);
      end
      if (!wr) begin
         checks++;
         if (cpu.READDATA !== exp_byte) begin
            errors++;
            $display("FAIL %s readdata: got %h, required %h", name, cpu.READDATA, exp_byte);
         end
      end
      @(posedge clk); #1;
      cpu.READ = 0; cpu.WRITE = 0;
      compare_traffic(name);
   endtask

   task automatic test_reset();
      rst = 1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (cpu.BUSYWAIT !== 0 || cpu.READDATA !== 8'h00 || mem.MEM_READ !== 0 ||
          mem.MEM_WRITE !== 0 || mem.MEM_ADDRESS !== 6'h00 || mem.MEM_WRITEDATA !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs: busy=%b rdata=%h mrd=%b mwr=%b maddr=%h mwdata=%h, required all 0",
                  cpu.BUSYWAIT, cpu.READDATA, mem.MEM_READ, mem.MEM_WRITE, mem.MEM_ADDRESS, mem.MEM_WRITEDATA);
      end
      @(posedge clk); #1; rst = 0;
      model_reset();
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_cold_miss();
      phys_mem[0] = 32'h11223344; ref_mem[0] = 32'h11223344;
      mem_lat = 1;
      do_op("cold_miss", 1, 0, 8'h03, 8'h00);
   endtask

   task automatic test_write_read_hit();
      do_op("write_hit", 0, 1, 8'h03, 8'h05);
      do_op("read_hit", 1, 0, 8'h03, 8'h00);
   endtask

   task automatic test_dirty_evict();
      mem_lat = 2;
      do_op("dirty_evict", 1, 0, 8'h23, 8'h00);
   endtask

   task automatic test_mem_stall();
      mem_lat = 5;
      do_op("mem_stall", 1, 0, 8'h44, 8'h00);
   endtask

   task automatic test_reset_mid_fetch();
      int n;
      mem_lat = 10;
      @(posedge clk); #1;
      cpu.READ = 1; cpu.ADDRESS = 8'h07;
      n = 0;
      do begin @(negedge clk); n++; end while (mem.MEM_READ !== 1'b1 && n < 20);
      checks++;
      if (mem.MEM_READ !== 1'b1) begin
         errors++;
         $display("FAIL midreset_enter_fetch: MEM_READ=%b, required 1", mem.MEM_READ);
      end
      @(posedge clk); #1; rst = 1;
      @(posedge clk); @(negedge clk);
      checks++;
      if (mem.MEM_READ !== 0 || mem.MEM_WRITE !== 0 || cpu.BUSYWAIT !== 0) begin
         errors++;
         $display("FAIL midreset_idle: MEM_READ=%b MEM_WRITE=%b BUSYWAIT=%b, required 0 0 0",
                  mem.MEM_READ, mem.MEM_WRITE, cpu.BUSYWAIT);
      end
      @(posedge clk); #1; rst = 0; cpu.READ = 0;
      model_reset();
      got_q.delete(); exp_q.delete();
      mem_lat = 1;
      do_op("midreset_rerun", 1, 0, 8'h03, 8'h00);
   endtask

   task automatic test_abandon_request();
      bit h; logic [7:0] rb; int n;
      mem_lat = 3;
      model_access(0, 8'h9A, 8'h00, h, rb);
      m_misses++;
      @(posedge clk); #1; cpu.READ = 1; cpu.ADDRESS = 8'h9A;
      @(negedge clk);
      checks++;
      if (cpu.BUSYWAIT !== 1'b1) begin
         errors++;
         $display("FAIL abandon_busy: BUSYWAIT=%b, required 1", cpu.BUSYWAIT);
      end
      @(posedge clk); #1; cpu.READ = 0;
      n = 0;
      do begin @(negedge clk); n++; end while (cpu.BUSYWAIT !== 1'b0 && n < 100);
      compare_traffic("abandon");
      do_op("abandon_rehit", 1, 0, 8'h9A, 8'h00);
   endtask

   task automatic test_random();
      logic [7:0] a, d; int r;
      for (int i = 0; i < 200; i++) begin
         a = {3'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
         d = 8'($urandom);
         r = $urandom_range(0, 3);
         mem_lat = $urandom_range(0, 3);
         do_op("random", r != 2, r >= 2, a, d);
      end
   endtask

   task automatic test_back_to_back();
      mem_lat = 0;
      for (int i = 0; i < 4; i++) do_op("b2b_store", 0, 1, 8'(8'hE0 + i), 8'(8'hA0 + i));
      for (int i = 0; i < 4; i++) do_op("b2b_load", 1, 0, 8'(8'hE0 + i), 8'h00);
   endtask

`ifdef DCACHE_STATS_EN
   task automatic test_stats();
      test_reset();
      mem_lat = 1;
      do_op("stats_miss", 1, 0, 8'h03, 8'h00);
      do_op("stats_hit", 1, 0, 8'h03, 8'h00);
      do_op("stats_hit2", 0, 1, 8'h02, 8'h77);
      do_op("stats_miss2", 1, 0, 8'h63, 8'h00);
      @(negedge clk);
      checks++;
      if (hit_count !== 16'(m_hits) || miss_count !== 16'(m_misses)) begin
         errors++;
         $display("FAIL stats_counts: hits=%0d misses=%0d, required %0d %0d", hit_count, miss_count, m_hits, m_misses);
      end
      test_reset();
      @(negedge clk);
      checks++;
      if (hit_count !== 16'd0 || miss_count !== 16'd0) begin
         errors++;
         $display("FAIL stats_reset: hits=%0d misses=%0d, required 0 0", hit_count, miss_count);
      end
   endtask
`endif

   initial begin
      cpu.READ = 0; cpu.WRITE = 0; cpu.ADDRESS = 8'h00; cpu.WRITEDATA = 8'h00;
      mem.MEM_BUSYWAIT = 0; mem.MEM_READDATA = 32'h0;
      for (int i = 0; i < 64; i++) begin phys_mem[i] = $urandom; ref_mem[i] = phys_mem[i]; end
      test_reset();
      test_cold_miss();
      test_write_read_hit();
      test_dirty_evict();
      test_mem_stall();
      test_reset_mid_fetch();
      test_abandon_request();
      test_back_to_back();
      test_random();
`ifdef DCACHE_STATS_EN
      test_stats();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache controller between the 8-bit CPU data port and the block-wide data memory.
- Replaces the direct CPU-to-data-memory connection in cpu_tb.
- Sequences all memory traffic: hit service, dirty-block writeback and block fetch.
- Stalls the CPU through BUSYWAIT.

Parameters:
- ADDR_W, 8, CPU byte-address width.
- INDEX_BITS, 3, log2 of the number of cache blocks (8 blocks).
- OFFSET_BITS, 2, log2 of bytes per block (4 bytes, 32-bit block).
- TAG_BITS, ADDR_W-INDEX_BITS-OFFSET_BITS (3), derived; not overridable.

Ports:
- CLK  in  1  system clock; all state changes on posedge.
- RESET  in  1  synchronous, active-high reset.
- READ  in  1  CPU load request.
- WRITE  in  1  CPU store request.
- ADDRESS  in  8  CPU byte address: tag[7:5], index[4:2], offset[1:0].
- WRITEDATA  in  8  CPU store byte.
- READDATA  out  8  CPU load byte.
- BUSYWAIT  out  1  CPU stall.
- MEM_READ  out  1  memory block-read request.
- MEM_WRITE  out  1  memory block-write request.
- MEM_ADDRESS  out  6  block address {tag,index}.
- MEM_WRITEDATA  out  32  block being written back; byte0 = offset 0 in bits [7:0].
- MEM_READDATA  in  32  fetched block.
- MEM_BUSYWAIT  in  1  memory busy; a transfer is complete when this is low while a request is held.

Behaviour:
- Storage: 8 entries, each {valid, dirty, tag[2:0], data[31:0]}.
- Reset: all valid and dirty bits cleared, state IDLE. READDATA=0, BUSYWAIT=0, MEM_READ=0, MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0. Data and tag contents are don't-care.
- Reset mid-transaction: abandons the transaction and forces IDLE at the same edge. Dirty data in flight is lost; this is accepted.
- Request: READ|WRITE high. If both are high, the request is treated as a store; the read is ignored.
- hit = valid[index] & (tag[index]==ADDRESS tag). Evaluated combinationally.
- State IDLE:
  - No request: BUSYWAIT=0.
  - Read hit: READDATA = selected byte combinationally (same cycle); BUSYWAIT=0; zero-stall.
  - Write hit: BUSYWAIT=0; byte written and dirty set at the next posedge; zero-stall.
  - Miss with clean or invalid victim: BUSYWAIT=1 combinationally; next state FETCH.
  - Miss with valid and dirty victim: BUSYWAIT=1 combinationally; next state WRITEBACK.
- State WRITEBACK:
  - MEM_WRITE=1, MEM_ADDRESS={victim tag,index}, MEM_WRITEDATA=victim block, BUSYWAIT=1.
  - When MEM_BUSYWAIT=0 at posedge: go to FETCH; the victim is not yet modified.
- State FETCH:
  - MEM_READ=1, MEM_ADDRESS={req tag,index}, BUSYWAIT=1.
  - When MEM_BUSYWAIT=0 at posedge: store MEM_READDATA, set tag, valid=1, dirty=0; go to IDLE.
  - The request then hits in IDLE; BUSYWAIT drops combinationally that cycle.
- MEM_READ and MEM_WRITE are never high simultaneously and are 0 in IDLE.
- Request deasserted during WRITEBACK/FETCH: the sequence completes anyway; the block is still allocated.
- Address outputs are held stable for the whole transfer.

Optional Feature:
- DCACHE_STATS_EN defined:
  - Adds outputs HIT_COUNT[15:0] and MISS_COUNT[15:0].
  - A request counts once, on its first IDLE cycle: hit -> HIT_COUNT+1, miss -> MISS_COUNT+1. The later hit after a fill does not count.
  - Counters saturate at 16'hFFFF and clear on RESET.
- Undefined: ports and counter logic are absent; behaviour is otherwise identical.

Decomposition:
- Package dcache_pkg:
  - State enum {IDLE, WRITEBACK, FETCH}.
  - Constants ADDR_W, INDEX_BITS, OFFSET_BITS, TAG_BITS, NUM_BLOCKS, BLOCK_W=32.
  - Field-slice helper functions for tag/index/offset.
- One sub-module, dcache_block_array:
  - Tag, valid, dirty and data storage.
  - Byte write port, block fill port, synchronous valid/dirty clear on RESET.
  - Combinational read of the indexed entry.
- dcache_controller holds the FSM, hit compare, byte mux and memory interface.

Test Plan:
- Cold read miss: after RESET, READ ADDRESS=0x03 with memory block 0 = 0x11223344 -> BUSYWAIT=1, one FETCH with MEM_ADDRESS=0, then READDATA=0x11, BUSYWAIT=0, valid[0]=1, dirty[0]=0.
- Write hit then read hit: WRITE 0x05 to 0x03, then READ 0x03 -> no BUSYWAIT on either; READDATA=0x05; dirty[0]=1; no memory traffic.
- Dirty eviction: with the block above dirty, READ 0x23 (tag 1, index 0) -> WRITEBACK MEM_ADDRESS=0x00, MEM_WRITEDATA=0x05223344, then FETCH MEM_ADDRESS=0x08, ordered, never overlapping.
- Memory stall: MEM_BUSYWAIT held high 5 cycles in FETCH -> MEM_READ and MEM_ADDRESS stable for all 5 cycles; fill only on the first low cycle.
- Reset mid-FETCH: assert RESET during FETCH -> next edge IDLE, MEM_READ=0, BUSYWAIT=0; repeating READ 0x03 misses again.
- DCACHE_STATS_EN: run the sequence miss, hit, hit, miss -> HIT_COUNT=2, MISS_COUNT=2; after RESET both are 0.
